// File: rtl/mips_trace_buffer.sv
// mips_trace_buffer: circular PC/instruction trace capture with PC-match trigger and valid/ready drain
module mips_trace_buffer #(
  parameter int WIDTH        = 32,
  parameter int DEPTH        = 16,
  parameter int POST_TRIGGER = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       arm,
  input  logic                       trig_en,
  input  logic [WIDTH-1:0]           trig_pc,
  input  logic                       cap_valid,
  input  logic [WIDTH-1:0]           cap_pc,
  input  logic [WIDTH-1:0]           cap_instr,
  output logic [1:0]                 state,
  output logic                       triggered,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [WIDTH-1:0]           rd_pc,
  output logic [WIDTH-1:0]           rd_instr,
  output logic                       rd_last,
  output logic                       done
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW:0] FULL = CW'(DEPTH);
  localparam logic [AW:0] PT   = CW'(POST_TRIGGER);
  localparam logic [AW:0] ONE  = CW'(1);
  typedef enum logic [1:0] {IDLE, ARMED, POST, READOUT} state_t;
  state_t            st;
  logic [AW-1:0]     wr_ptr, rd_ptr, wr_nxt;
  logic [AW:0]       post_cnt, cnt_nxt;
  logic              hit, post_end, accept;
  logic [2*WIDTH-1:0] mem [DEPTH];
  assign state    = st;
  assign accept   = cap_valid & (st == ARMED | st == POST);
  assign hit      = st == ARMED & cap_valid & trig_en & (cap_pc == trig_pc);
  assign post_end = hit ? (PT == '0) : (st == POST & cap_valid & post_cnt == ONE);
  assign wr_nxt   = wr_ptr + AW'(1);
  assign cnt_nxt  = count == FULL ? count : count + ONE;
  assign rd_valid = st == READOUT;
  assign rd_last  = rd_valid & count == ONE;
  assign {rd_pc, rd_instr} = rd_valid ? mem[rd_ptr] : '0;
  // Buffer contents are never reset; only the pointers define what is valid.
  always_ff @(posedge clock)
    if (accept) mem[wr_ptr] <= {cap_pc, cap_instr};
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      st        <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      post_cnt  <= '0;
      triggered <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (st)
        IDLE: if (arm) begin
          st     <= ARMED;
          wr_ptr <= '0;
          count  <= '0;
        end
        ARMED, POST: if (cap_valid) begin
          wr_ptr    <= wr_nxt;
          count     <= cnt_nxt;
          post_cnt  <= hit ? PT : (st == POST ? post_cnt - ONE : post_cnt);
          triggered <= triggered | hit;
          st        <= post_end ? READOUT : (hit ? POST : st);
          // Oldest entry sits at the write pointer once the ring has wrapped.
          if (post_end) rd_ptr <= cnt_nxt == FULL ? wr_nxt : '0;
        end
        READOUT: if (rd_ready) begin
          rd_ptr <= rd_ptr + AW'(1);
          count  <= count - ONE;
          if (count == ONE) begin
            st        <= IDLE;
            triggered <= 1'b0;
            done      <= 1'b1;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mips_trace_buffer.sv
// tb_mips_trace_buffer: scoreboard bench for two trace-buffer instances (POST_TRIGGER=2 and 0)
module tb_mips_trace_buffer;
  localparam int W = 32;
  localparam int D = 4;
  localparam int P = 2;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;
  logic arm, trig_en, cap_valid, rd_ready, triggered, rd_valid, rd_last, done;
  logic [W-1:0] trig_pc, cap_pc, cap_instr, rd_pc, rd_instr;
  logic [1:0] state;
  logic [2:0] count;
  logic b_arm, b_trig_en, b_cap_valid, b_rd_ready, b_triggered, b_rd_valid, b_rd_last, b_done;
  logic [W-1:0] b_trig_pc, b_cap_pc, b_cap_instr, b_rd_pc, b_rd_instr;
  logic [1:0] b_state;
  logic [2:0] b_count;
  mips_trace_buffer #(.WIDTH(W), .DEPTH(D), .POST_TRIGGER(P)) dut (
    .clock(clock), .reset(reset), .arm(arm), .trig_en(trig_en), .trig_pc(trig_pc),
    .cap_valid(cap_valid), .cap_pc(cap_pc), .cap_instr(cap_instr), .state(state),
    .triggered(triggered), .count(count), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_pc(rd_pc), .rd_instr(rd_instr), .rd_last(rd_last), .done(done));
  mips_trace_buffer #(.WIDTH(W), .DEPTH(D), .POST_TRIGGER(0)) dut0 (
    .clock(clock), .reset(reset), .arm(b_arm), .trig_en(b_trig_en), .trig_pc(b_trig_pc),
    .cap_valid(b_cap_valid), .cap_pc(b_cap_pc), .cap_instr(b_cap_instr), .state(b_state),
    .triggered(b_triggered), .count(b_count), .rd_valid(b_rd_valid), .rd_ready(b_rd_ready),
    .rd_pc(b_rd_pc), .rd_instr(b_rd_instr), .rd_last(b_rd_last), .done(b_done));
  int n_chk = 0;
  int n_err = 0;
  logic [63:0] sb[$];
  logic [63:0] q1[$];
  int m_state = 0;
  int m_post = 0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [W-1:0] ins(input logic [W-1:0] pc);
    return pc * 3 + 32'h2400_0000;
  endfunction
  task automatic step;
    @(negedge clock);
  endtask
  task automatic feed(input logic [W-1:0] pc, input logic v);
    cap_valid = v;
    cap_pc    = pc;
    cap_instr = ins(pc);
    step();
    if (v && (m_state == 1 || m_state == 2)) begin
      sb.push_back({pc, ins(pc)});
      if (sb.size() > D) void'(sb.pop_front());
      if (m_state == 1 && trig_en && pc == trig_pc) begin
        m_state = (P == 0) ? 3 : 2;
        m_post  = P;
      end else if (m_state == 2) begin
        m_post--;
        if (m_post == 0) m_state = 3;
      end
    end
    check("state", 64'(state), 64'(m_state));
    check("triggered", 64'(triggered), 64'(m_state >= 2));
    check("count", 64'(count), 64'(sb.size()));
  endtask
  task automatic arm_it;
    arm = 1'b1;
    step();
    arm = 1'b0;
    m_state = 1;
    check("arm", 64'(state), 64'd1);
  endtask
  task automatic capture(input logic [W-1:0] tp, input bit gaps);
    trig_pc = tp;
    arm_it();
    for (int i = 0; i < 7 && m_state != 3; i++) begin
      feed(32'(i * 4), 1'b1);
      if (gaps && m_state == 2) feed(32'hdead_0000, 1'b0);
    end
    cap_valid = 1'b0;
  endtask
  task automatic drain(input int stall_at);
    logic [63:0] e;
    int i;
    i = 0;
    while (sb.size() > 0 && i < 3 * D) begin
      e = sb[0];
      check("rd_valid", 64'(rd_valid), 64'd1);
      check("rd_data", {rd_pc, rd_instr}, e);
      check("rd_last", 64'(rd_last), 64'(sb.size() == 1));
      check("done_low", 64'(done), 64'd0);
      if (i == stall_at) begin
        rd_ready = 1'b0;
        repeat (5) begin
          step();
          check("hold_data", {rd_pc, rd_instr}, e);
          check("hold_valid", 64'(rd_valid), 64'd1);
          check("hold_count", 64'(count), 64'(sb.size()));
        end
      end
      rd_ready = 1'b1;
      step();
      void'(sb.pop_front());
      i++;
    end
    rd_ready = 1'b0;
    check("done", 64'(done), 64'd1);
    check("idle", 64'(state), 64'd0);
    check("trig_clr", 64'(triggered), 64'd0);
    check("rd_valid_off", 64'(rd_valid), 64'd0);
    step();
    check("done_pulse", 64'(done), 64'd0);
    m_state = 0;
  endtask
  task automatic async_reset;
    #2 reset = 1'b1;
    #1;
    check("rst_state", 64'(state), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_trig", 64'(triggered), 64'd0);
    check("rst_rd_valid", 64'(rd_valid), 64'd0);
    #1 reset = 1'b0;
    sb.delete();
    m_state = 0;
  endtask
  initial begin
    {arm, cap_valid, rd_ready, trig_pc, cap_pc, cap_instr} = '0;
    {b_arm, b_cap_valid, b_rd_ready, b_cap_pc, b_cap_instr} = '0;
    trig_en   = 1'b1;
    b_trig_en = 1'b1;
    b_trig_pc = 32'h8;
    step();
    step();
    check("reset_state", 64'(state), 64'd0);
    check("reset_count", 64'(count), 64'd0);
    reset = 1'b0;
    step();
    check("idle_state", 64'(state), 64'd0);
    check("idle_rd", {rd_pc, rd_instr, 31'd0, rd_valid}, 64'd0);
    capture(32'h10, 1'b0);
    check("full_count", 64'(count), 64'd4);
    drain(1);
    capture(32'h0, 1'b0);
    check("first_trig_count", 64'(count), 64'd3);
    drain(-1);
    capture(32'h10, 1'b1);
    drain(-1);
    trig_en = 1'b0;
    arm_it();
    for (int i = 0; i < 7; i++) feed(32'(i * 4), 1'b1);
    cap_valid = 1'b0;
    trig_en = 1'b1;
    async_reset();
    trig_pc = 32'h10;
    arm_it();
    for (int i = 0; i < 5; i++) feed(32'(i * 4), 1'b1);
    cap_valid = 1'b0;
    check("mid_post", 64'(state), 64'd2);
    async_reset();
    capture(32'h10, 1'b0);
    rd_ready = 1'b1;
    step();
    void'(sb.pop_front());
    rd_ready = 1'b0;
    check("mid_read_count", 64'(count), 64'd3);
    async_reset();
    capture(32'h10, 1'b0);
    drain(-1);
    b_arm = 1'b1;
    step();
    check("b_arm", 64'(b_state), 64'd1);
    for (int i = 0; i < 3; i++) begin
      b_cap_valid = 1'b1;
      b_cap_pc    = 32'(i * 4);
      b_cap_instr = ins(b_cap_pc);
      step();
      q1.push_back({b_cap_pc, b_cap_instr});
      check("b_state", 64'(b_state), (i == 2) ? 64'd3 : 64'd1);
      check("b_count", 64'(b_count), 64'(i + 1));
    end
    check("b_trig", 64'(b_triggered), 64'd1);
    b_cap_valid = 1'b0;
    step();
    check("b_arm_ignored", 64'(b_state), 64'd3);
    b_arm = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("b_rd_data", {b_rd_pc, b_rd_instr}, q1.pop_front());
      check("b_rd_last", 64'(b_rd_last), 64'(i == 2));
      b_rd_ready = 1'b1;
      step();
    end
    b_rd_ready = 1'b0;
    check("b_done", 64'(b_done), 64'd1);
    check("b_idle", 64'(b_state), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/mips_trace_buffer.md
# mips_trace_buffer

Parametrised instruction-trace capture block for the single-cycle MIPS core. Each cycle a sample (PC, instruction) is offered by the core; once armed, the block records samples into a circular buffer of DEPTH entries, stops a programmable number of samples after a PC-match trigger, then drains the captured window oldest-first over a valid/ready read port. It replaces ad-hoc `$monitor` tracing with a synthesizable, checkable trace window.

## Interface

- WIDTH, 32: width of captured PC and instruction fields.
- DEPTH, 16: buffer entries; power of two, ≥ 2.
- POST_TRIGGER, 8: samples captured after the trigger sample; 0 ≤ POST_TRIGGER ≤ DEPTH-1.

- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high; clears all state.
- arm  in  1  start request; honoured only in IDLE.
- trig_en  in  1  enables PC-match trigger.
- trig_pc  in  WIDTH  trigger PC value.
- cap_valid  in  1  sample present this cycle.
- cap_pc  in  WIDTH  sample PC.
- cap_instr  in  WIDTH  sample instruction.
- state  out  2  IDLE=0, ARMED=1, POST=2, READOUT=3.
- triggered  out  1  high from the edge that writes the trigger sample until return to IDLE.
- count  out  $clog2(DEPTH)+1  valid entries held (saturates at DEPTH).
- rd_valid  out  1  read data valid (high throughout READOUT).
- rd_ready  in  1  consumer accepts read data.
- rd_pc  out  WIDTH  oldest unread PC.
- rd_instr  out  WIDTH  oldest unread instruction.
- rd_last  out  1  current read entry is the final one.
- done  out  1  one-cycle pulse on the final accepted read.

## Operation

- Reset: state=IDLE, wr_ptr=rd_ptr=0, count=0, post counter=0; triggered, rd_valid, rd_last, done=0; rd_pc/rd_instr=0. Buffer contents need not be cleared.
- IDLE: cap_valid ignored. arm=1 → ARMED next edge; wr_ptr and count cleared.
- ARMED: every cap_valid writes {cap_pc, cap_instr} at wr_ptr; wr_ptr increments mod DEPTH; count increments, saturating at DEPTH (oldest overwritten). Trigger = cap_valid & trig_en & (cap_pc == trig_pc). Trigger sample is written like any other; triggered set; post counter loaded with POST_TRIGGER; next state POST, or READOUT when POST_TRIGGER=0. trig_en=0 keeps ARMED indefinitely (wrap continues).
- POST: every cap_valid writes as in ARMED and decrements post counter; the write that brings it to 0 moves to READOUT. Cycles without cap_valid do not count.
- READOUT entry: rd_ptr = (count==DEPTH) ? wr_ptr : 0 (oldest entry). cap_valid ignored.
- READOUT: rd_valid=1; rd_pc/rd_instr combinationally reflect entry rd_ptr; rd_last = (count==1). Handshake rd_valid & rd_ready pops: rd_ptr increments mod DEPTH, count decrements. Pop with rd_last=1 → done pulse, state IDLE, triggered cleared. rd_ready low holds data and rd_valid stable.
- arm outside IDLE is ignored. Reset in any state, including mid-READOUT, returns to the reset values immediately.

## Timing

- All state updates on rising clock; reset asynchronous.
- Sample accepted on the edge where cap_valid=1; count/state reflect it after that edge.
- Trigger at edge T: triggered=1 and state=POST (or READOUT) visible after T.
- Last post sample at edge P: rd_valid=1 after P; first data available that cycle (zero added latency).
- Drain throughput one entry per cycle with rd_ready held high; done asserted for the single cycle following the final pop edge, together with state=IDLE.

## Test plan

- DEPTH=4, POST_TRIGGER=2, trig_pc=0x10; arm, then PCs 0x0,0x4,…,0x18 back-to-back → READOUT after 0x18; count=4; reads 0xC,0x10,0x14,0x18, rd_last only on 0x18, done pulse, state=0.
- Same config, trig_pc=0x0 → triggers on first sample; reads 0x0,0x4,0x8, count=3 at READOUT entry.
- Gaps: cap_valid toggled 1/0 in POST → post counter advances only on valid cycles; window contents identical to back-to-back case.
- Backpressure: rd_ready low 5 cycles in READOUT → rd_pc/rd_instr/rd_valid stable, count unchanged; resume drains in order.
- POST_TRIGGER=0 instance: trigger sample is last entry; READOUT after trigger edge; arm during ARMED/READOUT ignored.
- Reset asserted mid-POST and mid-READOUT (asynchronously, between edges) → state=0, count=0, triggered=0, rd_valid=0 immediately; fresh arm works normally.
